// File: rtl/pc_pkg.sv
// pc_pkg: shared state, fault-code and op-priority definitions for pc_stack_unit
package pc_pkg;
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_INC, OP_LOAD, OP_CALL, OP_RET} op_t;
    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UDF  = 2'b10;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: parametrised LIFO; push/pop update depth, dout is combinational top-of-stack
//   clk, r (sync active-high reset) | push, pop, din | dout, depth, full, empty
module ret_stack #(
    parameter int W = 16,
    parameter int D = 8
) (
    input  logic                   clk,
    input  logic                   r,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(D+1)-1:0] depth,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(D);
    localparam int DW = $clog2(D+1);
    logic [W-1:0]  mem [D];
    logic [AW-1:0] top;
    assign top   = AW'(depth - 1'b1);
    assign dout  = mem[top];
    assign full  = depth == DW'(D);
    assign empty = depth == '0;
    always_ff @(posedge clk)
        if (push && !full) mem[AW'(depth)] <= din;
    always_ff @(posedge clk)
        if (r) depth <= '0;
        else if (push && !full) depth <= depth + 1'b1;
        else if (pop && !empty) depth <= depth - 1'b1;
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with increment/load/call/return, return-address stack and fault FSM
//   clk, r (sync active-high reset) | en, load, call, ret, halt, resume, oe, bus_in
//   bus_out, bus_oe, pc, depth, full, empty, halted, fault, fault_code
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 8,
    parameter int                INC         = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                             clk,
    input  logic                             r,
    input  logic                             en,
    input  logic                             load,
    input  logic                             call,
    input  logic                             ret,
    input  logic                             halt,
    input  logic                             resume,
    input  logic                             oe,
    input  logic [ADDR_W-1:0]                bus_in,
    output logic [ADDR_W-1:0]                bus_out,
    output logic                             bus_oe,
    output logic [ADDR_W-1:0]                pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             full,
    output logic                             empty,
    output logic                             halted,
    output logic                             fault,
    output logic [1:0]                       fault_code
);
    state_t            state, state_n;
    op_t               op;
    logic [ADDR_W-1:0] pc_n, pc_inc, top;
    logic [1:0]        fc_n;
    logic              push, pop;
    assign pc_inc = pc + ADDR_W'(INC);
    assign op     = ret ? OP_RET : call ? OP_CALL : load ? OP_LOAD : en ? OP_INC : OP_NONE;
    ret_stack #(.W(ADDR_W), .D(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .r     (r),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (top),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk)
        if (r) begin
            state      <= RUN;
            pc         <= RESET_VEC;
            fault_code <= FC_NONE;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            fault_code <= fc_n;
        end
    // halt outranks every op; overflow/underflow leave pc and stack untouched
    always_comb begin
        state_n = state;
        pc_n    = pc;
        fc_n    = fault_code;
        push    = 1'b0;
        pop     = 1'b0;
        if (state == RUN && halt) state_n = HALT;
        else if (state == RUN)
            case (op)
                OP_RET:
                    if (empty) begin
                        state_n = FAULT;
                        fc_n    = FC_UDF;
                    end else begin
                        pc_n = top;
                        pop  = 1'b1;
                    end
                OP_CALL:
                    if (full) begin
                        state_n = FAULT;
                        fc_n    = FC_OVF;
                    end else begin
                        pc_n = bus_in;
                        push = 1'b1;
                    end
                OP_LOAD: pc_n = bus_in;
                OP_INC:  pc_n = pc_inc;
                default: ;
            endcase
        else if (state == HALT && resume) state_n = RUN;
    end
    assign bus_oe  = oe && state != FAULT;
    assign bus_out = bus_oe ? pc : '0;
    assign halted  = state == HALT;
    assign fault   = state == FAULT;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: vector table, hand sequences and randomized model comparison for pc_stack_unit
module tb_pc_stack_unit;
    localparam logic [7:0] R = 8'h80, EN = 8'h40, LD = 8'h20, CA = 8'h10;
    localparam logic [7:0] RT = 8'h08, HA = 8'h04, RS = 8'h02, OE = 8'h01;
    logic        clk = 1'b0;
    logic        r, en, load, call, ret, halt, resume, oe;
    logic [15:0] bus_in, bus_out, pc;
    logic        bus_oe, full, empty, halted, fault;
    logic [3:0]  depth;
    logic [1:0]  fault_code;
    int          n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    pc_stack_unit dut (
        .clk(clk), .r(r), .en(en), .load(load), .call(call), .ret(ret),
        .halt(halt), .resume(resume), .oe(oe), .bus_in(bus_in),
        .bus_out(bus_out), .bus_oe(bus_oe), .pc(pc), .depth(depth),
        .full(full), .empty(empty), .halted(halted), .fault(fault),
        .fault_code(fault_code)
    );
    typedef struct {
        logic [7:0]  ctl;
        logic [15:0] bin;
        logic [15:0] pc;
        logic [3:0]  d;
        logic [1:0]  fc;
        logic        h;
        logic        f;
        logic        boe;
        logic [15:0] bout;
    } vec_t;
    vec_t vecs [28];
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask
    task automatic step(input logic [7:0] ctl, input logic [15:0] b);
        {r, en, load, call, ret, halt, resume, oe} = ctl;
        bus_in = b;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_all(input string nm, input int idx, input logic [15:0] e_pc, input logic [3:0] e_d,
                           input logic [1:0] e_fc, input logic e_h, input logic e_f,
                           input logic e_boe, input logic [15:0] e_bout);
        chk({nm, ".pc"}, idx, 32'(pc), 32'(e_pc));
        chk({nm, ".depth"}, idx, 32'(depth), 32'(e_d));
        chk({nm, ".full"}, idx, 32'(full), 32'(e_d == 4'd8));
        chk({nm, ".empty"}, idx, 32'(empty), 32'(e_d == 4'd0));
        chk({nm, ".fault_code"}, idx, 32'(fault_code), 32'(e_fc));
        chk({nm, ".halted"}, idx, 32'(halted), 32'(e_h));
        chk({nm, ".fault"}, idx, 32'(fault), 32'(e_f));
        chk({nm, ".bus_oe"}, idx, 32'(bus_oe), 32'(e_boe));
        chk({nm, ".bus_out"}, idx, 32'(bus_out), 32'(e_bout));
    endtask
    // reference model: abstract state 0=running 1=halted 2=faulted, stack as a queue
    int          m_st;
    logic [15:0] m_pc;
    logic [1:0]  m_fc;
    logic [15:0] m_q [$];
    task automatic model(input logic [7:0] ctl, input logic [15:0] b);
        if (ctl[7]) begin
            m_st = 0; m_pc = 16'h0000; m_fc = 2'd0; m_q.delete();
        end else if (m_st == 0) begin
            if (ctl & HA) m_st = 1;
            else if (ctl & RT) begin
                if (m_q.size() == 0) begin m_st = 2; m_fc = 2'd2; end
                else m_pc = m_q.pop_back();
            end else if (ctl & CA) begin
                if (m_q.size() == 8) begin m_st = 2; m_fc = 2'd1; end
                else begin m_q.push_back(m_pc + 16'd1); m_pc = b; end
            end else if (ctl & LD) m_pc = b;
            else if (ctl & EN) m_pc = m_pc + 16'd1;
        end else if (m_st == 1 && (ctl & RS)) m_st = 0;
    endtask
    initial begin
        vecs[0]  = '{R,          16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000};
        vecs[1]  = '{EN,         16'h0000, 16'h0001, 0, 0, 0, 0, 0, 16'h0000};
        vecs[2]  = '{EN,         16'h0000, 16'h0002, 0, 0, 0, 0, 0, 16'h0000};
        vecs[3]  = '{EN,         16'h0000, 16'h0003, 0, 0, 0, 0, 0, 16'h0000};
        vecs[4]  = '{LD,         16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0, 16'h0000};
        vecs[5]  = '{EN,         16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000};
        vecs[6]  = '{LD,         16'h0010, 16'h0010, 0, 0, 0, 0, 0, 16'h0000};
        vecs[7]  = '{CA,         16'h0200, 16'h0200, 1, 0, 0, 0, 0, 16'h0000};
        vecs[8]  = '{RT,         16'h0000, 16'h0011, 0, 0, 0, 0, 0, 16'h0000};
        vecs[9]  = '{RT,         16'h0000, 16'h0011, 0, 2, 0, 1, 0, 16'h0000};
        vecs[10] = '{OE,         16'h0000, 16'h0011, 0, 2, 0, 1, 0, 16'h0000};
        vecs[11] = '{EN|LD,      16'h1234, 16'h0011, 0, 2, 0, 1, 0, 16'h0000};
        vecs[12] = '{R,          16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000};
        vecs[13] = '{LD,         16'h0041, 16'h0041, 0, 0, 0, 0, 0, 16'h0000};
        vecs[14] = '{CA,         16'h0300, 16'h0300, 1, 0, 0, 0, 0, 16'h0000};
        vecs[15] = '{RT|CA|LD|EN,16'h0555, 16'h0042, 0, 0, 0, 0, 0, 16'h0000};
        vecs[16] = '{CA,         16'h0100, 16'h0100, 1, 0, 0, 0, 0, 16'h0000};
        vecs[17] = '{HA|EN,      16'h0000, 16'h0100, 1, 0, 1, 0, 0, 16'h0000};
        vecs[18] = '{EN|LD,      16'h0777, 16'h0100, 1, 0, 1, 0, 0, 16'h0000};
        vecs[19] = '{RS,         16'h0000, 16'h0100, 1, 0, 0, 0, 0, 16'h0000};
        vecs[20] = '{EN,         16'h0000, 16'h0101, 1, 0, 0, 0, 0, 16'h0000};
        vecs[21] = '{EN|OE,      16'h0000, 16'h0102, 1, 0, 0, 0, 1, 16'h0102};
        vecs[22] = '{RT,         16'h0000, 16'h0043, 0, 0, 0, 0, 0, 16'h0000};
        vecs[23] = '{RS|EN,      16'h0000, 16'h0044, 0, 0, 0, 0, 0, 16'h0000};
        vecs[24] = '{HA|RT,      16'h0000, 16'h0044, 0, 0, 1, 0, 0, 16'h0000};
        vecs[25] = '{RS,         16'h0000, 16'h0044, 0, 0, 0, 0, 0, 16'h0000};
        vecs[26] = '{RT,         16'h0000, 16'h0044, 0, 2, 0, 1, 0, 16'h0000};
        vecs[27] = '{RS|OE,      16'h0000, 16'h0044, 0, 2, 0, 1, 0, 16'h0000};
        for (int i = 0; i < 28; i++) begin
            step(vecs[i].ctl, vecs[i].bin);
            chk_all("vec", i, vecs[i].pc, vecs[i].d, vecs[i].fc, vecs[i].h, vecs[i].f, vecs[i].boe, vecs[i].bout);
        end
        // fill the stack to its legal maximum, then overflow
        step(R, 16'h0000);
        step(LD, 16'h1000);
        for (int i = 0; i < 8; i++) begin
            step(CA, 16'h2000 + 16'(i));
            chk_all("nest", i, 16'h2000 + 16'(i), 4'(i + 1), 0, 0, 0, 0, 16'h0000);
        end
        step(CA, 16'h3000);
        chk_all("ovf", 0, 16'h2007, 8, 1, 0, 1, 0, 16'h0000);
        step(EN, 16'h0000);
        chk_all("ovf", 1, 16'h2007, 8, 1, 0, 1, 0, 16'h0000);
        step(LD, 16'h4444);
        chk_all("ovf", 2, 16'h2007, 8, 1, 0, 1, 0, 16'h0000);
        step(R, 16'h0000);
        chk_all("ovf", 3, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        // reset with a call pending discards the call
        step(CA, 16'h0500);
        step(R | CA, 16'h0600);
        chk_all("rstcall", 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        // unwind a filled stack in LIFO order
        for (int i = 0; i < 8; i++) step(CA, 16'h5000 + 16'(i));
        for (int i = 7; i >= 0; i--) begin
            step(RT, 16'h0000);
            chk_all("unwind", i, (i == 0) ? 16'h0001 : 16'h5000 + 16'(i), 4'(i), 0, 0, 0, 0, 16'h0000);
        end
        // randomized run against the queue model
        step(R, 16'h0000);
        model(R, 16'h0000);
        for (int i = 0; i < 600; i++) begin
            logic [7:0]  c;
            logic [15:0] b;
            logic        m_oe;
            c = 8'h00;
            if ($urandom_range(0, 39) == 0) c |= R;
            if ($urandom_range(0, 1) == 0)  c |= EN;
            if ($urandom_range(0, 3) == 0)  c |= LD;
            if ($urandom_range(0, 2) == 0)  c |= CA;
            if ($urandom_range(0, 3) == 0)  c |= RT;
            if ($urandom_range(0, 11) == 0) c |= HA;
            if ($urandom_range(0, 3) == 0)  c |= RS;
            if ($urandom_range(0, 1) == 0)  c |= OE;
            b = 16'($urandom);
            step(c, b);
            model(c, b);
            m_oe = c[0] && m_st != 2;
            chk_all("rand", i, m_pc, 4'(m_q.size()), m_fc, m_st == 1, m_st == 2, m_oe, m_oe ? m_pc : 16'h0000);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
